apu_reg_interface: RTL and testbench
====================================

Name: apu_reg_interface

Overview:
- CPU-facing register front end for the APU. Decodes CPU bus writes to $4000-$4017 (5-bit offset) into the triangle channel's three control bytes, channel enables and frame sequencer control.
- Generates the one-cycle load/clear strobes and the delayed frame-sequencer reset.
- Serves $4015 status reads.
- Sits directly upstream of triangleChannel and frameSequencer; replaces the constant drivers of inputReg1..3 in the apu top.

Parameters:
- RESET_DELAY_EVEN, 3, cycles from a $4017 write on an even phase to the frame_reset pulse
- RESET_DELAY_ODD, 4, cycles from a $4017 write on an odd phase to the frame_reset pulse

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- cpu_addr  in  5  register offset from $4000 (0x00-0x17)
- cpu_data  in  8  write data
- cpu_we  in  1  write strobe, one cycle per write
- cpu_re  in  1  read strobe
- cpu_rdata  out  8  registered read data
- tri_len_nonzero  in  1  triangle length counter != 0
- frame_irq_in  in  1  frame interrupt flag from the sequencer
- tri_reg1  out  8  $4008: {controlFlag, counterReload[6:0]}
- tri_reg2  out  8  $400A: timer[7:0]
- tri_reg3  out  8  $400B: {lengthCounterLoad[4:0], timer[10:8]}
- tri_load  out  1  pulse: $400B written (length load, linear reload flag set)
- tri_enable  out  1  $4015 bit 2
- tri_len_clear  out  1  pulse: $4015 written with bit 2 = 0
- frame_mode  out  1  $4017 bit 7 (0 = 4-step, 1 = 5-step)
- frame_irq_inhibit  out  1  $4017 bit 6
- frame_reset  out  1  pulse: delayed frame sequencer reset
- irq_clear  out  1  pulse: $4015 read

Behaviour:
- Reset (reset = 0 at a clk edge):
  - All outputs go to 0, including the pulse outputs.
  - The phase bit and the delay counter clear. The pending-reset flag clears.
  - Reset mid-countdown cancels the pending frame_reset.
- Phase:
  - 1-bit toggle every clk (0 = even), starting at 0 after reset.
- Writes (cpu_we = 1, registered on the same edge):
  - 0x08 -> tri_reg1; 0x0A -> tri_reg2.
  - 0x0B -> tri_reg3, and tri_load = 1 for exactly the next cycle.
  - 0x15 -> tri_enable = data[2]; if data[2] = 0, tri_len_clear = 1 for exactly one cycle.
  - 0x17 -> frame_mode = data[7] and frame_irq_inhibit = data[6], updated immediately. The delay counter loads RESET_DELAY_EVEN or RESET_DELAY_ODD according to the phase in the write cycle.
  - All other offsets (including 0x09, and 0x00-0x07 / 0x0C-0x14 for the unimplemented channels) are ignored with no side effects.
- Pulse outputs:
  - Registered; high for one cycle, beginning the cycle after the write edge.
  - Back-to-back writes to the same address give back-to-back pulses (stays high).
- Frame reset countdown:
  - Counter is 3 bits wide. It decrements each cycle while pending.
  - When it reaches 1, frame_reset = 1 on the following cycle and pending clears.
  - Latency: write edge to the frame_reset high cycle = N cycles, where N is the loaded delay.
  - If frame_mode = 1 at expiry, frame_reset is still a single pulse. The sequencer owns the immediate half/quarter-frame clock.
- Rewrite of $4017 while pending:
  - The countdown restarts from the new delay. Only one frame_reset is produced, for the latest write.
- Reads (cpu_re = 1, addr 0x15):
  - cpu_rdata at the next edge = {1'b0, frame_irq_in, 3'b000, tri_len_nonzero, 2'b00}.
  - irq_clear pulses for one cycle.
  - Any other read address returns 8'h00 with no pulse.
  - cpu_rdata holds its value until the next read.
- Simultaneous cpu_we and cpu_re:
  - Both are honoured. Read data reflects the inputs sampled in that cycle, not the effect of the write.
- Widths:
  - Data passes through unmodified; there is no arithmetic except the delay counter.

Decomposition:
- Shared package/header apu_defs: register offset constants (ADDR_TRI_LINEAR = 5'h08, ADDR_TRI_TLO = 5'h0A, ADDR_TRI_THI = 5'h0B, ADDR_STATUS = 5'h15, ADDR_FRAME = 5'h17) and the status bit positions (TRI_STATUS_BIT = 2, FRAME_IRQ_BIT = 6). The future pulse/noise channels reuse them.
- One natural sub-module: apu_frame_reset_delay (phase toggle, delay counter, pending flag, pulse out).
- The decoder and register file stay in the parent.

Test Plan:
- Reset then writes $4008 = 8'hE4, $400A = 8'hC8, $400B = 8'h09 -> tri_reg1 = E4, tri_reg2 = C8, tri_reg3 = 09; tri_load high exactly one cycle, after the $400B edge only.
- Write $4017 = 8'h80 on an even phase -> frame_mode = 1 next cycle; frame_reset pulses once, 3 cycles after the write edge. Repeat on an odd phase -> 4 cycles.
- Write $4017, then a second $4017 write 2 cycles later -> exactly one frame_reset, timed from the second write; drive reset = 0 during a countdown -> no pulse.
- Write $4015 = 8'h04 -> tri_enable = 1, no tri_len_clear; write $4015 = 8'h00 -> tri_enable = 0, tri_len_clear one-cycle pulse.
- tri_len_nonzero = 1, frame_irq_in = 1, read $4015 -> cpu_rdata = 8'h44, irq_clear one pulse; read $4014 -> 8'h00, no pulse.
- Writes to 0x00, 0x09, 0x0C, 0x16 with data FF -> no output changes and no pulses; simultaneous we($400B) + re($4015) -> both the load pulse and the status data are correct.

Source files
------------

// File: rtl/apu_defs.sv
// rtl/apu_defs.sv - APU register offsets, status bit positions and status byte helper
package apu_defs;

  localparam logic [4:0] ADDR_TRI_LINEAR = 5'h08;
  localparam logic [4:0] ADDR_TRI_TLO    = 5'h0A;
  localparam logic [4:0] ADDR_TRI_THI    = 5'h0B;
  localparam logic [4:0] ADDR_STATUS     = 5'h15;
  localparam logic [4:0] ADDR_FRAME      = 5'h17;

  localparam int TRI_STATUS_BIT = 2;
  localparam int FRAME_IRQ_BIT  = 6;

  function automatic logic [7:0] status_byte(input logic tri_nz, input logic frame_irq);
    logic [7:0] s;
    s = 8'h00;
    s[TRI_STATUS_BIT] = tri_nz;
    s[FRAME_IRQ_BIT]  = frame_irq;
    return s;
  endfunction

endpackage

// File: rtl/apu_reg_interface_if.sv
// rtl/apu_reg_interface_if.sv - CPU register bus between the CPU side and the APU register front end
interface apu_reg_interface_if;

  logic [4:0] cpu_addr;
  logic [7:0] cpu_data;
  logic       cpu_we;
  logic       cpu_re;
  logic [7:0] cpu_rdata;

  modport master (
    output cpu_addr,
    output cpu_data,
    output cpu_we,
    output cpu_re,
    input  cpu_rdata
  );

  modport slave (
    input  cpu_addr,
    input  cpu_data,
    input  cpu_we,
    input  cpu_re,
    output cpu_rdata
  );

endinterface

// File: rtl/apu_frame_reset_delay.sv
// rtl/apu_frame_reset_delay.sv - phase-dependent delayed frame sequencer reset pulse
module apu_frame_reset_delay #(
  parameter int RESET_DELAY_EVEN = 3,
  parameter int RESET_DELAY_ODD  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic frame_reset
);

  localparam logic [2:0] DELAY_EVEN = 3'(RESET_DELAY_EVEN);
  localparam logic [2:0] DELAY_ODD  = 3'(RESET_DELAY_ODD);

  logic       phase_q, phase_d;
  logic       pending_q, pending_d;
  logic       pulse_q, pulse_d;
  logic [2:0] count_q, count_d;

  // A new load always wins, so a rewrite restarts the countdown and only the latest one fires.
  always_comb begin
    phase_d   = ~phase_q;
    count_d   = count_q;
    pending_d = pending_q;
    pulse_d   = 1'b0;
    if (load) begin
      count_d   = phase_q ? DELAY_ODD : DELAY_EVEN;
      pending_d = 1'b1;
    end else if (pending_q) begin
      if (count_q == 3'd1) begin
        pulse_d   = 1'b1;
        pending_d = 1'b0;
      end else begin
        count_d = count_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q   <= 1'b0;
      count_q   <= 3'd0;
      pending_q <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      pulse_q   <= pulse_d;
    end
  end

  assign frame_reset = pulse_q;

endmodule

// File: rtl/apu_reg_interface.sv
// rtl/apu_reg_interface.sv - APU CPU register decoder, triangle/frame register file and status read
module apu_reg_interface
  import apu_defs::*;
#(
  parameter int RESET_DELAY_EVEN = 3,
  parameter int RESET_DELAY_ODD  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  apu_reg_interface_if.slave   cpu,
  input  logic                 tri_len_nonzero,
  input  logic                 frame_irq_in,
  output logic [7:0]           tri_reg1,
  output logic [7:0]           tri_reg2,
  output logic [7:0]           tri_reg3,
  output logic                 tri_load,
  output logic                 tri_enable,
  output logic                 tri_len_clear,
  output logic                 frame_mode,
  output logic                 frame_irq_inhibit,
  output logic                 frame_reset,
  output logic                 irq_clear
);

  logic [7:0] tri_reg1_q, tri_reg1_d;
  logic [7:0] tri_reg2_q, tri_reg2_d;
  logic [7:0] tri_reg3_q, tri_reg3_d;
  logic       tri_load_q, tri_load_d;
  logic       tri_enable_q, tri_enable_d;
  logic       tri_len_clear_q, tri_len_clear_d;
  logic       frame_mode_q, frame_mode_d;
  logic       frame_inhibit_q, frame_inhibit_d;
  logic       irq_clear_q, irq_clear_d;
  logic [7:0] rdata_q, rdata_d;
  logic       frame_load;

  always_comb begin
    tri_reg1_d      = tri_reg1_q;
    tri_reg2_d      = tri_reg2_q;
    tri_reg3_d      = tri_reg3_q;
    tri_enable_d    = tri_enable_q;
    frame_mode_d    = frame_mode_q;
    frame_inhibit_d = frame_inhibit_q;
    rdata_d         = rdata_q;
    tri_load_d      = 1'b0;
    tri_len_clear_d = 1'b0;
    irq_clear_d     = 1'b0;
    frame_load      = 1'b0;

    if (cpu.cpu_we) begin
      case (cpu.cpu_addr)
        ADDR_TRI_LINEAR: tri_reg1_d = cpu.cpu_data;
        ADDR_TRI_TLO:    tri_reg2_d = cpu.cpu_data;
        ADDR_TRI_THI: begin
          tri_reg3_d = cpu.cpu_data;
          tri_load_d = 1'b1;
        end
        ADDR_STATUS: begin
          tri_enable_d    = cpu.cpu_data[TRI_STATUS_BIT];
          tri_len_clear_d = ~cpu.cpu_data[TRI_STATUS_BIT];
        end
        ADDR_FRAME: begin
          frame_mode_d    = cpu.cpu_data[7];
          frame_inhibit_d = cpu.cpu_data[6];
          frame_load      = 1'b1;
        end
        default: ;
      endcase
    end

    // Status reflects the live inputs of this cycle, independent of any concurrent write.
    if (cpu.cpu_re) begin
      if (cpu.cpu_addr == ADDR_STATUS) begin
        rdata_d     = status_byte(tri_len_nonzero, frame_irq_in);
        irq_clear_d = 1'b1;
      end else begin
        rdata_d = 8'h00;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tri_reg1_q      <= 8'h00;
      tri_reg2_q      <= 8'h00;
      tri_reg3_q      <= 8'h00;
      tri_load_q      <= 1'b0;
      tri_enable_q    <= 1'b0;
      tri_len_clear_q <= 1'b0;
      frame_mode_q    <= 1'b0;
      frame_inhibit_q <= 1'b0;
      irq_clear_q     <= 1'b0;
      rdata_q         <= 8'h00;
    end else begin
      tri_reg1_q      <= tri_reg1_d;
      tri_reg2_q      <= tri_reg2_d;
      tri_reg3_q      <= tri_reg3_d;
      tri_load_q      <= tri_load_d;
      tri_enable_q    <= tri_enable_d;
      tri_len_clear_q <= tri_len_clear_d;
      frame_mode_q    <= frame_mode_d;
      frame_inhibit_q <= frame_inhibit_d;
      irq_clear_q     <= irq_clear_d;
      rdata_q         <= rdata_d;
    end
  end

  apu_frame_reset_delay #(
    .RESET_DELAY_EVEN (RESET_DELAY_EVEN),
    .RESET_DELAY_ODD  (RESET_DELAY_ODD)
  ) u_frame_reset_delay (
    .clk         (clk),
    .reset       (reset),
    .load        (frame_load),
    .frame_reset (frame_reset)
  );

  assign tri_reg1          = tri_reg1_q;
  assign tri_reg2          = tri_reg2_q;
  assign tri_reg3          = tri_reg3_q;
  assign tri_load          = tri_load_q;
  assign tri_enable        = tri_enable_q;
  assign tri_len_clear     = tri_len_clear_q;
  assign frame_mode        = frame_mode_q;
  assign frame_irq_inhibit = frame_inhibit_q;
  assign irq_clear         = irq_clear_q;
  assign cpu.cpu_rdata     = rdata_q;

endmodule

// File: tb/tb_apu_reg_interface.sv
// tb/tb_apu_reg_interface.sv - vector table and directed frame-reset sequences for apu_reg_interface
module tb_apu_reg_interface;

  logic clk = 1'b0;
  logic reset;
  logic tri_len_nonzero, frame_irq_in;
  logic [7:0] tri_reg1, tri_reg2, tri_reg3;
  logic tri_load, tri_enable, tri_len_clear;
  logic frame_mode, frame_irq_inhibit, frame_reset, irq_clear;

  int total = 0;
  int bad = 0;

  apu_reg_interface_if cpu_bus ();

  apu_reg_interface #(.RESET_DELAY_EVEN(3), .RESET_DELAY_ODD(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .cpu               (cpu_bus),
    .tri_len_nonzero   (tri_len_nonzero),
    .frame_irq_in      (frame_irq_in),
    .tri_reg1          (tri_reg1),
    .tri_reg2          (tri_reg2),
    .tri_reg3          (tri_reg3),
    .tri_load          (tri_load),
    .tri_enable        (tri_enable),
    .tri_len_clear     (tri_len_clear),
    .frame_mode        (frame_mode),
    .frame_irq_inhibit (frame_irq_inhibit),
    .frame_reset       (frame_reset),
    .irq_clear         (irq_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] addr;
    logic [7:0] data;
    logic       we;
    logic       re;
    logic       nz;
    logic       irq;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] r3;
    logic       load;
    logic       en;
    logic       clr;
    logic [7:0] rdata;
    logic       irqc;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] a, input logic [7:0] d, input logic we, input logic re);
    cpu_bus.cpu_addr = a;
    cpu_bus.cpu_data = d;
    cpu_bus.cpu_we   = we;
    cpu_bus.cpu_re   = re;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(5'h00, 8'h00, 1'b0, 1'b0);
    tri_len_nonzero = 1'b0;
    frame_irq_in    = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic count_pulses(input int window, output int hits, output int first);
    hits  = 0;
    first = -1;
    for (int k = 1; k <= window; k++) begin
      step();
      if (frame_reset === 1'b1) begin
        hits++;
        if (first < 0) first = k;
      end
    end
  endtask

  task automatic frame_test(input string nm, input bit odd, input logic [7:0] d, input int exp_n);
    int hits, first;
    do_reset();
    if (odd) step();
    drive(5'h17, d, 1'b1, 1'b0);
    step();
    chk({nm, " frame_mode"}, 32'(frame_mode), 32'(d[7]));
    chk({nm, " irq_inhibit"}, 32'(frame_irq_inhibit), 32'(d[6]));
    chk({nm, " early frame_reset"}, 32'(frame_reset), 32'd0);
    drive(5'h00, 8'h00, 1'b0, 1'b0);
    count_pulses(10, hits, first);
    chk({nm, " pulse count"}, 32'(hits), 32'd1);
    chk({nm, " pulse latency"}, 32'(first), 32'(exp_n));
  endtask

  initial begin
    int hits, first;

    //            addr   data   we re nz irq  r1     r2     r3     ld en cl rdata  irqc
    vecs[0]  = '{5'h08, 8'hE4, 1, 0, 0, 0, 8'hE4, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0};
    vecs[1]  = '{5'h0A, 8'hC8, 1, 0, 0, 0, 8'hE4, 8'hC8, 8'h00, 0, 0, 0, 8'h00, 0};
    vecs[2]  = '{5'h0B, 8'h09, 1, 0, 0, 0, 8'hE4, 8'hC8, 8'h09, 1, 0, 0, 8'h00, 0};
    vecs[3]  = '{5'h00, 8'h00, 0, 0, 0, 0, 8'hE4, 8'hC8, 8'h09, 0, 0, 0, 8'h00, 0};
    vecs[4]  = '{5'h15, 8'h04, 1, 0, 0, 0, 8'hE4, 8'hC8, 8'h09, 0, 1, 0, 8'h00, 0};
    vecs[5]  = '{5'h15, 8'h00, 1, 0, 0, 0, 8'hE4, 8'hC8, 8'h09, 0, 0, 1, 8'h00, 0};
    vecs[6]  = '{5'h00, 8'h00, 0, 0, 0, 0, 8'hE4, 8'hC8, 8'h09, 0, 0, 0, 8'h00, 0};
    vecs[7]  = '{5'h15, 8'h00, 0, 1, 1, 1, 8'hE4, 8'hC8, 8'h09, 0, 0, 0, 8'h44, 1};
    vecs[8]  = '{5'h00, 8'h00, 0, 0, 1, 1, 8'hE4, 8'hC8, 8'h09, 0, 0, 0, 8'h44, 0};
    vecs[9]  = '{5'h14, 8'h00, 0, 1, 1, 1, 8'hE4, 8'hC8, 8'h09, 0, 0, 0, 8'h00, 0};
    vecs[10] = '{5'h00, 8'hFF, 1, 0, 0, 0, 8'hE4, 8'hC8, 8'h09, 0, 0, 0, 8'h00, 0};
    vecs[11] = '{5'h09, 8'hFF, 1, 0, 0, 0, 8'hE4, 8'hC8, 8'h09, 0, 0, 0, 8'h00, 0};
    vecs[12] = '{5'h0C, 8'hFF, 1, 0, 0, 0, 8'hE4, 8'hC8, 8'h09, 0, 0, 0, 8'h00, 0};
    vecs[13] = '{5'h16, 8'hFF, 1, 0, 0, 0, 8'hE4, 8'hC8, 8'h09, 0, 0, 0, 8'h00, 0};
    vecs[14] = '{5'h0B, 8'h5A, 1, 1, 1, 1, 8'hE4, 8'hC8, 8'h5A, 1, 0, 0, 8'h00, 0};
    vecs[15] = '{5'h0B, 8'h33, 1, 0, 0, 0, 8'hE4, 8'hC8, 8'h33, 1, 0, 0, 8'h00, 0};
    vecs[16] = '{5'h15, 8'h04, 1, 1, 0, 1, 8'hE4, 8'hC8, 8'h33, 0, 1, 0, 8'h40, 1};
    vecs[17] = '{5'h15, 8'h00, 1, 1, 1, 0, 8'hE4, 8'hC8, 8'h33, 0, 0, 1, 8'h04, 1};
    vecs[18] = '{5'h15, 8'h00, 1, 0, 0, 0, 8'hE4, 8'hC8, 8'h33, 0, 0, 1, 8'h04, 0};
    vecs[19] = '{5'h00, 8'h00, 0, 0, 0, 0, 8'hE4, 8'hC8, 8'h33, 0, 0, 0, 8'h04, 0};

    reset = 1'b0;
    drive(5'h00, 8'h00, 1'b0, 1'b0);
    tri_len_nonzero = 1'b0;
    frame_irq_in    = 1'b0;
    step();
    step();
    reset = 1'b1;

    chk("reset tri_reg1", 32'(tri_reg1), 32'h0);
    chk("reset tri_reg2", 32'(tri_reg2), 32'h0);
    chk("reset tri_reg3", 32'(tri_reg3), 32'h0);
    chk("reset pulses", 32'({tri_load, tri_len_clear, frame_reset, irq_clear}), 32'h0);
    chk("reset flags", 32'({tri_enable, frame_mode, frame_irq_inhibit}), 32'h0);
    chk("reset rdata", 32'(cpu_bus.cpu_rdata), 32'h0);

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].addr, vecs[i].data, vecs[i].we, vecs[i].re);
      tri_len_nonzero = vecs[i].nz;
      frame_irq_in    = vecs[i].irq;
      step();
      chk($sformatf("v%0d tri_reg1", i), 32'(tri_reg1), 32'(vecs[i].r1));
      chk($sformatf("v%0d tri_reg2", i), 32'(tri_reg2), 32'(vecs[i].r2));
      chk($sformatf("v%0d tri_reg3", i), 32'(tri_reg3), 32'(vecs[i].r3));
      chk($sformatf("v%0d tri_load", i), 32'(tri_load), 32'(vecs[i].load));
      chk($sformatf("v%0d tri_enable", i), 32'(tri_enable), 32'(vecs[i].en));
      chk($sformatf("v%0d tri_len_clear", i), 32'(tri_len_clear), 32'(vecs[i].clr));
      chk($sformatf("v%0d cpu_rdata", i), 32'(cpu_bus.cpu_rdata), 32'(vecs[i].rdata));
      chk($sformatf("v%0d irq_clear", i), 32'(irq_clear), 32'(vecs[i].irqc));
      chk($sformatf("v%0d frame ctrl", i), 32'({frame_mode, frame_irq_inhibit, frame_reset}), 32'h0);
    end

    frame_test("even", 1'b0, 8'h80, 3);
    frame_test("odd", 1'b1, 8'hC0, 4);

    // Rewrite two cycles later: second write also lands on an even phase.
    do_reset();
    drive(5'h17, 8'h00, 1'b1, 1'b0);
    step();
    drive(5'h00, 8'h00, 1'b0, 1'b0);
    step();
    chk("rewrite no pulse yet", 32'(frame_reset), 32'd0);
    drive(5'h17, 8'h80, 1'b1, 1'b0);
    step();
    chk("rewrite frame_mode", 32'(frame_mode), 32'd1);
    drive(5'h00, 8'h00, 1'b0, 1'b0);
    count_pulses(10, hits, first);
    chk("rewrite pulse count", 32'(hits), 32'd1);
    chk("rewrite pulse latency", 32'(first), 32'd3);

    // Reset during the countdown cancels the pending pulse.
    do_reset();
    drive(5'h17, 8'h80, 1'b1, 1'b0);
    step();
    drive(5'h00, 8'h00, 1'b0, 1'b0);
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("cancel frame_mode", 32'(frame_mode), 32'd0);
    count_pulses(10, hits, first);
    chk("cancel pulse count", 32'(hits), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
